cobra_run_ctrl: RTL
===================

# cobra_run_ctrl

Run/halt sequencer for the cobra single-cycle core. Produces one enable, `core_en`, that gates the PC update and register-file write. This lets the core be held in reset-like idle, free-run, single-stepped, or halted by an external request, a halt instruction or an address breakpoint. It sits between the board controls and the core, observing the core's PC and fetched instruction, and counts retired instructions.

## Interface
Parameters:
- `PC_W`, 32, width of the PC and breakpoint compare
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding treated as HALT (never executed)
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `run_req`  in  1  request free-run (level, sampled each cycle)
- `step_req`  in  1  request single instruction (level, sampled each cycle)
- `stop_req`  in  1  request halt (level, sampled each cycle)
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint PC
- `pc`  in  PC_W  current core PC
- `instr`  in  32  instruction currently fetched at `pc`
- `core_en`  out  1  1 = core executes `instr` this cycle (PC advances, RF write allowed)
- `state`  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT
- `halted`  out  1  state == HALT
- `halt_cause`  out  2  0 none, 1 stop_req, 2 halt word, 3 breakpoint
- `retired`  out  CNT_W  instructions executed since reset

## Operation
- Request priority when asserted together: stop_req > step_req > run_req.
- Stop condition: `stop_req`, or `instr == HALT_WORD`, or a breakpoint hit.
- Breakpoint hit: `bp_en && pc == bp_addr && !bp_skip`.
- `core_en` is combinational: (state is RUN or STEP) and no stop condition. A halting instruction or breakpoint address is therefore never executed.
- `bp_skip` is an internal flag:
  - set on every entry to RUN or STEP;
  - cleared after the first cycle with `core_en == 1`.
  - This lets execution resume from a breakpoint PC.
- State transitions, evaluated on the clock edge:
  - IDLE: step_req → STEP; run_req → RUN; otherwise stay. stop_req is ignored.
  - RUN: stop condition → HALT and latch its cause. halt_cause priority is stop_req(1) > halt word(2) > breakpoint(3). Otherwise stay.
  - STEP: always → HALT. Cause is 1 if stop_req; else 2 or 3 if that stop condition holds; else 1.
  - HALT: step_req → STEP; run_req → RUN; otherwise stay. halt_cause is held and cleared to 0 on leaving HALT.
- A HALT_WORD at `pc` causes immediate re-halt on any RUN or STEP entry. Execution stays stuck until reset or until the PC changes externally.
- `retired` increments by 1 on every edge where `core_en == 1`. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `core_en` 0, `halted` 0, `halt_cause` 0, `retired` 0, `bp_skip` 1.
- Request-to-execute latency: a request seen at edge N gives `core_en` high in cycle N+1 (first execution edge N+2).
- STEP: exactly one cycle with `core_en` = 1, or zero cycles if the stop condition holds, then HALT.
- Stop: same-cycle. `core_en` drops combinationally in the cycle in which the stop condition is present, and `halted` rises after the next edge.
- Reset asserted mid-RUN: `core_en` falls immediately (asynchronously).
- Input hold: level requests held for multiple cycles re-trigger per the transition rules. A held step_req therefore alternates STEP/HALT, i.e. one instruction every 2 cycles.

## Configuration
- `COBRA_RUN_CTRL_BP_EN` defined: breakpoint compare and `bp_skip` are implemented as described.
- Not defined: `bp_en`/`bp_addr` remain as ports but are ignored. Breakpoint hit is constant 0 and halt_cause 3 never occurs.

## Test plan
- Reset then idle: hold all requests 0 for 10 cycles → state 00, core_en 0, retired 0.
- Free-run and stop:
  - run_req pulse at cycle 1 → core_en 1 from cycle 2.
  - stop_req at cycle 12 → core_en 0 in cycle 12, state 11, halt_cause 1, retired 10.
- Halt word: run with instr = 32'hFFFF_FFFF presented at pc 5 → core_en 0 at pc 5, state HALT, halt_cause 2, PC stays 5.
- Breakpoint (macro defined):
  - bp_en 1, bp_addr 3, run → halt at pc 3 with halt_cause 3 and pc-3 instruction not executed.
  - step_req → exactly one instruction executes (pc 3→4), state HALT, halt_cause 1.
- Priority: stop_req, step_req and run_req all 1 in HALT → state goes to STEP, then HALT with cause 1. From RUN with all three → HALT, cause 1.
- Counter wrap: CNT_W 4, run 17 instructions → retired reads 1.

Source files
------------

// File: rtl/cobra_run_ctrl.sv
// cobra_run_ctrl: run/halt sequencer for the cobra single-cycle core.
// Produces core_en, which gates PC update and register-file write. It supports
// idle, free-run, single-step and halt on stop request, halt word or breakpoint.
// It also counts retired instructions.
// Optional feature macro: COBRA_RUN_CTRL_BP_EN. When defined, the PC breakpoint
// compare and its resume-skip flag are built. When undefined, bp_en and bp_addr
// are accepted but ignored.
module cobra_run_ctrl #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_STOP = 2'd1,
    C_WORD = 2'd2,
    C_BP   = 2'd3
  } cause_t;

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;

  logic word_hit;
  logic bp_hit;
  logic stop_cond;

  assign word_hit = (instr == HALT_WORD);

`ifdef COBRA_RUN_CTRL_BP_EN
  // Set on each entry to RUN/STEP so the first instruction may sit on bp_addr;
  // this is what lets execution resume from a breakpoint.
  logic bp_skip;
  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  assign stop_cond = stop_req | word_hit | bp_hit;

  // Stop is same-cycle: a halting instruction or breakpoint PC is never executed.
  assign core_en = ((state_q == S_RUN) || (state_q == S_STEP)) && !stop_cond;

  // Next-state and halt-cause selection.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        // stop_req does not block a resume request; any stop in the next
        // cycle is handled from RUN/STEP.
        if (step_req) begin
          state_d = S_STEP;
          cause_d = C_NONE;
        end else if (run_req) begin
          state_d = S_RUN;
          cause_d = C_NONE;
        end
      end
      S_RUN: begin
        if (stop_cond) begin
          state_d = S_HALT;
          cause_d = stop_req ? C_STOP : (word_hit ? C_WORD : C_BP);
        end
      end
      S_STEP: begin
        // A completed step with no stop condition reports a stop-request cause.
        state_d = S_HALT;
        if (!stop_req && word_hit)    cause_d = C_WORD;
        else if (!stop_req && bp_hit) cause_d = C_BP;
        else                          cause_d = C_STOP;
      end
    endcase
  end

  // Sequencer state and latched halt cause.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Retired-instruction counter; wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (core_en) cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef COBRA_RUN_CTRL_BP_EN
  logic entering;
  assign entering = ((state_q == S_IDLE) || (state_q == S_HALT)) &&
                    ((state_d == S_RUN)  || (state_d == S_STEP));

  // Breakpoint skip: armed on entry, dropped after the first executed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bp_skip <= 1'b1;
    else if (entering) bp_skip <= 1'b1;
    else if (core_en)  bp_skip <= 1'b0;
  end
`endif

  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign retired    = cnt_q;

endmodule
